// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port among NUM_CH
// requesters; one transaction in flight, completion signalled by a valid pulse.
module mem_req_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_request,
    input  logic [NUM_CH-1:0]            ch_we_re,
    input  logic [NUM_CH*DATA_W/8-1:0]   ch_mask,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_address,
    input  logic [NUM_CH*DATA_W-1:0]     ch_data_in,
    output logic [NUM_CH-1:0]            ch_valid,
    output logic [DATA_W-1:0]            ch_data_out,
    output logic                         busy,
    output logic                         mem_request,
    output logic                         mem_we_re,
    output logic [DATA_W/8-1:0]          mem_mask,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_data_in,
    input  logic [DATA_W-1:0]            mem_data_out
);

    localparam int MASK_W = DATA_W / 8;
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                mem_we_q, mem_we_d;
    logic [MASK_W-1:0]   mem_mask_q, mem_mask_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                pick_valid;
    logic [GW-1:0]       pick;

    // grant_q doubles as last_grant: the search starts one past it.
    always_comb begin
        pick_valid = 1'b0;
        pick       = grant_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!pick_valid && ch_request[(int'(grant_q) + k) % NUM_CH]) begin
                pick_valid = 1'b1;
                pick       = GW'((int'(grant_q) + k) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            grant_q     <= GW'(NUM_CH - 1);
            mem_we_q    <= 1'b0;
            mem_mask_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            mem_we_q    <= mem_we_d;
            mem_mask_q  <= mem_mask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // WAIT always lasts at least one cycle so the final WAIT cycle is exactly
    // MEM_LAT cycles after ISSUE; read data is captured on the edge into RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        mem_we_d    = mem_we_q;
        mem_mask_d  = mem_mask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick;
                    mem_we_d    = ch_we_re[pick];
                    mem_mask_d  = ch_mask[int'(pick)*MASK_W +: MASK_W];
                    mem_addr_d  = ch_address[int'(pick)*ADDR_W +: ADDR_W];
                    mem_wdata_d = ch_data_in[int'(pick)*DATA_W +: DATA_W];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_data_out;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ch_valid    = '0;
        mem_request = (state_q == S_ISSUE);
        busy        = (state_q != S_IDLE);
        if (state_q == S_RESP) begin
            ch_valid[grant_q] = 1'b1;
        end
    end

    assign ch_data_out = rdata_q;
    assign mem_we_re   = mem_we_q;
    assign mem_mask    = mem_mask_q;
    assign mem_address = mem_addr_q;
    assign mem_data_in = mem_wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance
// share channel stimulus, each backed by its own small memory model.
module tb_mem_req_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  mask;
    logic [23:0] addr;
    logic [63:0] wdata;

    logic [1:0]  v1, v3;
    logic [31:0] do1, do3;
    logic        busy1, busy3, mreq1, mreq3, mwe1, mwe3;
    logic [3:0]  mmask1, mmask3;
    logic [11:0] maddr1, maddr3;
    logic [31:0] mdin1, mdin3, mdout1, mdout3;

    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] p3 [3];

    int checks;
    int failures;

    mem_req_arbiter #(.NUM_CH(2), .ADDR_W(12), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .ch_request(req), .ch_we_re(we), .ch_mask(mask),
        .ch_address(addr), .ch_data_in(wdata), .ch_valid(v1), .ch_data_out(do1),
        .busy(busy1), .mem_request(mreq1), .mem_we_re(mwe1), .mem_mask(mmask1),
        .mem_address(maddr1), .mem_data_in(mdin1), .mem_data_out(mdout1)
    );

    mem_req_arbiter #(.NUM_CH(2), .ADDR_W(12), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .ch_request(req), .ch_we_re(we), .ch_mask(mask),
        .ch_address(addr), .ch_data_in(wdata), .ch_valid(v3), .ch_data_out(do3),
        .busy(busy3), .mem_request(mreq3), .mem_we_re(mwe3), .mem_mask(mmask3),
        .mem_address(maddr3), .mem_data_in(mdin3), .mem_data_out(mdout3)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem1[16] = 32'hDEADBEEF;
        mem3[16] = 32'hDEADBEEF;
        mem1[4]  = 32'hAABBCCDD;
        mem3[4]  = 32'hAABBCCDD;
        mdout1   = 32'h0;
        for (int i = 0; i < 3; i++) p3[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (mreq1) begin
            for (int b = 0; b < 4; b++)
                if (mwe1 && mmask1[b]) mem1[maddr1[5:0]][8*b +: 8] <= mdin1[8*b +: 8];
            mdout1 <= mem1[maddr1[5:0]];
        end
    end

    always @(posedge clk) begin
        if (mreq3) begin
            for (int b = 0; b < 4; b++)
                if (mwe3 && mmask3[b]) mem3[maddr3[5:0]][8*b +: 8] <= mdin3[8*b +: 8];
            p3[0] <= mem3[maddr3[5:0]];
        end
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mdout3 = p3[2];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] req_during);
        rst = 1'b0;
        req = req_during;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; req = 2'b00; we = 2'b00; mask = 8'h00; addr = 24'h0; wdata = 64'h0;
        tick();
        tick();
        checks++; if (v1 !== 2'b00) begin failures++; $display("FAIL reset_valid: got %b exp 00", v1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy1); end
        checks++; if (mreq1 !== 1'b0) begin failures++; $display("FAIL reset_mem_request: got %b exp 0", mreq1); end
        checks++; if ({mwe1, mmask1, maddr1, mdin1} !== 49'h0) begin failures++; $display("FAIL reset_mem_fields: got %h exp 0", {mwe1, mmask1, maddr1, mdin1}); end
        checks++; if (do1 !== 32'h0) begin failures++; $display("FAIL reset_data_out: got %h exp 0", do1); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy_lat3: got %b exp 0", busy3); end
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        we = 2'b00; addr = {12'h010, 12'h000}; req = 2'b10;
        tick();
        checks++; if (mreq1 !== 1'b1) begin failures++; $display("FAIL single_mem_request: got %b exp 1", mreq1); end
        checks++; if (maddr1 !== 12'h010) begin failures++; $display("FAIL single_mem_address: got %h exp 010", maddr1); end
        checks++; if (mwe1 !== 1'b0) begin failures++; $display("FAIL single_mem_we: got %b exp 0", mwe1); end
        tick();
        checks++; if (v1 !== 2'b00) begin failures++; $display("FAIL single_valid_early: got %b exp 00", v1); end
        tick();
        checks++; if (v1 !== 2'b10) begin failures++; $display("FAIL single_valid: got %b exp 10", v1); end
        checks++; if (do1 !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got %h exp deadbeef", do1); end
        req = 2'b00;
        tick();
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b exp 0", busy1); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_v;
        logic [31:0] exp_d;
        we = 2'b00; addr = {12'h004, 12'h010};
        apply_reset(2'b11);
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_v = 2'b00;
            if (c % 4 == 3) exp_v = ((c / 4) % 2 == 1) ? 2'b10 : 2'b01;
            checks++; if (v1 !== exp_v) begin failures++; $display("FAIL rr_valid cycle %0d: got %b exp %b", c, v1, exp_v); end
            if (c % 4 == 3) begin
                exp_d = ((c / 4) % 2 == 1) ? 32'hAABBCCDD : 32'hDEADBEEF;
                checks++; if (do1 !== exp_d) begin failures++; $display("FAIL rr_data cycle %0d: got %h exp %h", c, do1, exp_d); end
            end
            if (c == 15) req = 2'b00;
            if (c == 16) begin
                checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rr_busy_end: got %b exp 0", busy1); end
            end
        end
    endtask

    task automatic test_write_then_read();
        we = 2'b01; mask = 8'h03; addr = {12'h000, 12'h004}; wdata = {32'h0, 32'h12345678}; req = 2'b01;
        tick();
        checks++; if (mreq1 !== 1'b1) begin failures++; $display("FAIL wr_mem_request: got %b exp 1", mreq1); end
        checks++; if (mwe1 !== 1'b1) begin failures++; $display("FAIL wr_mem_we: got %b exp 1", mwe1); end
        checks++; if (mmask1 !== 4'b0011) begin failures++; $display("FAIL wr_mem_mask: got %b exp 0011", mmask1); end
        checks++; if (mdin1 !== 32'h12345678) begin failures++; $display("FAIL wr_mem_data: got %h exp 12345678", mdin1); end
        checks++; if (maddr1 !== 12'h004) begin failures++; $display("FAIL wr_mem_address: got %h exp 004", maddr1); end
        tick();
        tick();
        checks++; if (v1 !== 2'b01) begin failures++; $display("FAIL wr_valid: got %b exp 01", v1); end
        checks++; if (do1 !== 32'hAABBCCDD) begin failures++; $display("FAIL wr_data_held: got %h exp aabbccdd", do1); end
        req = 2'b00; we = 2'b00;
        tick();
        req = 2'b01;
        tick();
        checks++; if (mwe1 !== 1'b0) begin failures++; $display("FAIL rd_mem_we: got %b exp 0", mwe1); end
        tick();
        tick();
        checks++; if (v1 !== 2'b01) begin failures++; $display("FAIL rd_valid: got %b exp 01", v1); end
        checks++; if (do1 !== 32'hAABB5678) begin failures++; $display("FAIL rd_merged_data: got %h exp aabb5678", do1); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_early_deassert();
        we = 2'b00; addr = {12'h000, 12'h010}; req = 2'b01;
        tick();
        checks++; if (mreq1 !== 1'b1) begin failures++; $display("FAIL early_mem_request: got %b exp 1", mreq1); end
        req = 2'b00;
        tick();
        tick();
        checks++; if (v1 !== 2'b01) begin failures++; $display("FAIL early_valid: got %b exp 01", v1); end
        checks++; if (do1 !== 32'hDEADBEEF) begin failures++; $display("FAIL early_data: got %h exp deadbeef", do1); end
        for (int c = 4; c <= 8; c++) begin
            tick();
            checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL early_busy cycle %0d: got %b exp 0", c, busy1); end
            checks++; if (mreq1 !== 1'b0) begin failures++; $display("FAIL early_no_reissue cycle %0d: got %b exp 0", c, mreq1); end
        end
    endtask

    task automatic test_lat3_latency();
        int n;
        we = 2'b00; addr = {12'h010, 12'h000};
        apply_reset(2'b00);
        req = 2'b10;
        n = 0;
        while (v3 === 2'b00 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != 5) begin failures++; $display("FAIL lat3_latency: got %0d exp 5", n); end
        checks++; if (v3 !== 2'b10) begin failures++; $display("FAIL lat3_valid: got %b exp 10", v3); end
        checks++; if (do3 !== 32'hDEADBEEF) begin failures++; $display("FAIL lat3_data: got %h exp deadbeef", do3); end
        req = 2'b00;
        tick();
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL lat3_busy_after: got %b exp 0", busy3); end
    endtask

    task automatic test_reset_mid_wait();
        we = 2'b00; addr = {12'h010, 12'h004};
        apply_reset(2'b00);
        req = 2'b01;
        tick();
        checks++; if (mreq3 !== 1'b1) begin failures++; $display("FAIL mid_issue: got %b exp 1", mreq3); end
        tick();
        checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL mid_wait_busy: got %b exp 1", busy3); end
        #2 rst = 1'b0;
        req = 2'b00;
        #1;
        checks++; if ({v3, busy3, mreq3} !== 4'b0) begin failures++; $display("FAIL mid_async_ctrl: got %b exp 0", {v3, busy3, mreq3}); end
        checks++; if ({mwe3, mmask3, maddr3, mdin3, do3} !== 81'h0) begin failures++; $display("FAIL mid_async_fields: got %h exp 0", {mwe3, mmask3, maddr3, mdin3, do3}); end
        tick();
        rst = 1'b1;
        req = 2'b11;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                checks++; if (maddr3 !== 12'h004) begin failures++; $display("FAIL mid_regrant_addr: got %h exp 004", maddr3); end
            end
            if (c < 5) begin
                checks++; if (v3 !== 2'b00) begin failures++; $display("FAIL mid_no_valid cycle %0d: got %b exp 00", c, v3); end
            end else begin
                checks++; if (v3 !== 2'b01) begin failures++; $display("FAIL mid_ch0_first: got %b exp 01", v3); end
            end
        end
        req = 2'b00;
        tick();
    endtask

    // ---------------- sequence & report ----------------
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read();
        test_early_deassert();
        test_lat3_latency();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
